// File: rtl/pipe_buf_stage.sv
// Pipeline register stage with valid/ready flow control, flush and a saturating stall counter.
// Define PIPE_BUF_SKID_EN to build the 2-entry skid buffer; otherwise a single register stage.
module pipe_buf_stage #(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter int                STALL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [STALL_W-1:0] stall_cnt
);

  // Handshake: a transfer happens on any cycle where valid && ready at the rising
  // edge; valid never depends on ready, and flush overrides every transfer.
  logic in_xfer;
  logic out_xfer;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  logic [STALL_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  // The stall count survives flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;

`ifdef PIPE_BUF_SKID_EN

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  main_q, main_d;
  logic [DATA_W-1:0]  skid_q, skid_d;
  logic               in_ready_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          case ({in_xfer, out_xfer})
            2'b10: begin
              skid_d  = in_data;
              state_d = FULL;
            end
            2'b01: state_d = EMPTY;
            2'b11: main_d  = in_data;
            default: state_d = ONE;
          endcase
        end
        FULL: begin
          // The skid entry is the next oldest, so it slides into main.
          if (out_xfer) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      main_q     <= NOP_VAL;
      skid_q     <= NOP_VAL;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  // in_ready comes straight from a flop, breaking the out_ready -> in_ready path.
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = out_valid ? main_q : NOP_VAL;

`else

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_xfer) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_xfer) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= NOP_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign in_ready  = out_ready || !valid_q;
  assign out_valid = valid_q;
  assign out_data  = valid_q ? data_q : NOP_VAL;

`endif

endmodule

// File: tb/tb_pipe_buf_stage.sv
// Bench for pipe_buf_stage: directed steps plus random traffic, checked against a payload queue model.
// Works for both builds; PIPE_BUF_SKID_EN selects the 2-entry expectations.
module tb_pipe_buf_stage;

  localparam int                DATA_W  = 32;
  localparam int                STALL_W = 4;
  localparam logic [DATA_W-1:0] NOP     = 32'hDEAD_BEEF;
`ifdef PIPE_BUF_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic               clk;
  logic               reset;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic [STALL_W-1:0] stall_cnt;

  pipe_buf_stage #(
    .DATA_W  (DATA_W),
    .NOP_VAL (NOP),
    .STALL_W (STALL_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [DATA_W-1:0]  exp_q[$];
  logic [STALL_W-1:0] exp_stall;
  bit                 known;
  int                 checks;
  int                 errors;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
  task automatic cycle(input logic rst, input logic fl, input logic iv,
                       input logic [DATA_W-1:0] id, input logic ordy);
    logic m_valid;
    logic m_ready;
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    @(negedge clk);
    if (known) begin
      m_valid = (exp_q.size() > 0);
      m_ready = (CAP == 2) ? (exp_q.size() < 2) : (ordy || (exp_q.size() == 0));
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
      chk("stall_cnt", {28'd0, stall_cnt}, {28'd0, exp_stall});
      if (m_valid) chk("out_data", out_data, exp_q[0]);
      else         chk("out_data_nop", out_data, NOP);
      if (rst) begin
        exp_q.delete();
        exp_stall = '0;
      end else begin
        if (m_valid && !ordy && (exp_stall != 4'hF)) exp_stall = exp_stall + 4'd1;
        if (fl) begin
          exp_q.delete();
        end else begin
          if (m_valid && ordy) void'(exp_q.pop_front());
          if (iv && m_ready) exp_q.push_back(id);
        end
      end
    end else if (rst) begin
      exp_q.delete();
      exp_stall = '0;
      known     = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    known     = 1'b0;
    exp_stall = '0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset held two cycles with a payload offered
    cycle(1'b1, 1'b0, 1'b1, 32'hA5, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'hA5, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Streaming
    cycle(1'b0, 1'b0, 1'b1, 32'h1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 32'h2, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 32'h3, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Backpressure then drain
    cycle(1'b0, 1'b0, 1'b1, 32'h10, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h11, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Flush with entries held and a payload offered
    cycle(1'b0, 1'b0, 1'b1, 32'h20, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h21, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'h77, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Reset mid-stall with entries held
    cycle(1'b0, 1'b0, 1'b1, 32'h30, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h31, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'h32, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Stall counter saturation
    cycle(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Random traffic with occasional flush
    for (int i = 0; i < 80; i++) begin
      cycle(1'b0, ($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)),
            $urandom, 1'($urandom_range(0, 1)));
    end
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
